// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for the 8-digit scan driver: data/control in,
// digit enables, segments and frame strobe out.
interface seg7_scan_driver_if;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_mask;
  logic        lz_blank;
  logic        blink_en;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (
    output load, data_in, dp_mask, lz_blank, blink_en,
    input  an, seg, frame_done
  );

  modport slave (
    input  load, data_in, dp_mask, lz_blank, blink_en,
    output an, seg, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 8-digit common-anode 7-seg scanner with frame-synchronous double
// buffering, leading-zero blanking, decimal points and blinking.
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_BITS = 5
) (
  input logic              clk,
  input logic              rst,
  seg7_scan_driver_if.slave bus
);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [31:0] RST_WORD = 32'hAA55_55AA;

  logic [PW-1:0]         presc_q, presc_d;
  logic [2:0]            idx_q, idx_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [31:0]           shadow_q, shadow_d;
  logic [31:0]           disp_q, disp_d;
  logic                  pend_q, pend_d;
  logic                  fd_q, fd_d;
  logic [7:0]            an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic       tick;
  logic       wrap;
  logic [3:0] nib;
  logic [6:0] hex;
  logic       hi_zero;
  logic       lz_hit;
  logic       blk_hit;

  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    wrap    = tick && (idx_q == 3'd7);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 1'b1 : idx_q;
    fd_d    = wrap;
    blink_d = wrap ? blink_q + 1'b1 : blink_q;

    shadow_d = bus.load ? bus.data_in : shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    // a load landing on the wrap bypasses the shadow so it shows at once
    if (wrap && bus.load) begin
      disp_d = bus.data_in;
      pend_d = 1'b0;
    end else if (wrap && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end else if (bus.load) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    nib = disp_q[{idx_q, 2'b00} +: 4];
    hex = 7'h7F;
    unique case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
    endcase

    // current nibble and everything above it are zero
    hi_zero = ((disp_q >> {idx_q, 2'b00}) == 32'd0);
    lz_hit  = bus.lz_blank && (idx_q != 3'd0) && hi_zero;
    blk_hit = bus.blink_en && blink_q[BLINK_BITS-1];

    an_d  = ~(8'd1 << idx_q);
    seg_d = {~bus.dp_mask[idx_q], hex};
    if (lz_hit || blk_hit) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= 3'd0;
      blink_q  <= '0;
      shadow_q <= RST_WORD;
      disp_q   <= RST_WORD;
      pend_q   <= 1'b0;
      fd_q     <= 1'b0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      fd_q     <= fd_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (SCAN_DIV=4, BLINK_BITS=2);
// edge E(n) is the n-th rising clk edge after reset release.
module tb_seg7_scan_driver;
  logic clk;
  logic rst;
  int   ncmp;
  int   nbad;
  int   edge_cnt;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(
    .SCAN_DIV  (4),
    .BLINK_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int e);
    while (edge_cnt < e) begin
      @(posedge clk);
      edge_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] an_e,
                         input logic [7:0] seg_e);
    chk(tag, {bus.an, bus.seg}, {an_e, seg_e});
  endtask

  task automatic chk_fd(input string tag, input logic fd_e);
    chk(tag, {15'd0, bus.frame_done}, {15'd0, fd_e});
  endtask

  initial begin
    ncmp = 0;
    nbad = 0;
    edge_cnt = 0;
    rst = 1'b1;
    bus.load = 1'b0;
    bus.data_in = 32'd0;
    bus.dp_mask = 8'h00;
    bus.lz_blank = 1'b0;
    bus.blink_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("reset_out", 8'hFF, 8'hFF);
    chk_fd("reset_fd", 1'b0);
    rst = 1'b0;
    edge_cnt = 0;

    goto(1);   chk_out("d0_A", 8'hFE, 8'h88);
    goto(9);   chk_out("d2_5", 8'hFB, 8'h92);
    goto(31);  chk_fd("fd_before", 1'b0);
    goto(32);  chk_fd("fd_pulse1", 1'b1);
    goto(33);  chk_fd("fd_after", 1'b0);
    goto(64);  chk_fd("fd_pulse2", 1'b1);
    goto(65);  chk_fd("fd_after2", 1'b0);

    // load mid-frame at digit 3; current frame keeps old data
    goto(77);
    bus.load = 1'b1;
    bus.data_in = 32'h0123ABCD;
    goto(78);
    bus.load = 1'b0;
    goto(81);  chk_out("old_d4", 8'hEF, 8'h92);
    goto(89);  chk_out("old_d6", 8'hBF, 8'h88);
    goto(93);  chk_out("old_d7", 8'h7F, 8'h88);
    goto(97);  chk_out("new_d0", 8'hFE, 8'hA1);
    goto(109); chk_out("new_d3", 8'hF7, 8'h88);
    goto(125); chk_out("new_d7", 8'h7F, 8'hC0);

    // load on the wrap edge itself
    goto(127);
    bus.load = 1'b1;
    bus.data_in = 32'h00000042;
    goto(128);
    bus.load = 1'b0;
    bus.lz_blank = 1'b1;
    goto(129); chk_out("wrap_ld_d0", 8'hFE, 8'hA4);
    goto(133); chk_out("lz_d1", 8'hFD, 8'h99);
    goto(137); chk_out("lz_d2", 8'hFF, 8'hFF);
    goto(140);
    bus.load = 1'b1;
    bus.data_in = 32'd0;
    goto(141);
    bus.load = 1'b0;
    goto(157); chk_out("lz_d7", 8'hFF, 8'hFF);
    goto(161); chk_out("lz_zero_d0", 8'hFE, 8'hC0);
    goto(165); chk_out("lz_zero_d1", 8'hFF, 8'hFF);

    bus.lz_blank = 1'b0;
    bus.dp_mask = 8'h01;
    goto(193); chk_out("dp_d0", 8'hFE, 8'h40);

    // blink counter is 2 in this frame (6 wraps so far)
    bus.blink_en = 1'b1;
    goto(197); chk_out("dp_d1_blink", 8'hFF, 8'hFF);
    goto(225); chk_out("blink_f3", 8'hFF, 8'hFF);
    goto(257); chk_out("blink_f0", 8'hFE, 8'h40);
    goto(289); chk_out("blink_f1", 8'hFE, 8'h40);
    goto(321); chk_out("blink_f2", 8'hFF, 8'hFF);
    bus.blink_en = 1'b0;

    goto(355);
    bus.load = 1'b1;
    bus.data_in = 32'h11111111;
    goto(356);
    bus.load = 1'b0;
    goto(374); chk_out("pre_rst_d5", 8'hDF, 8'hC0);

    // asynchronous reset in the middle of digit 5
    rst = 1'b1;
    #1;
    chk_out("async_rst", 8'hFF, 8'hFF);
    chk_fd("async_rst_fd", 1'b0);
    bus.dp_mask = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_cnt = 0;
    goto(1);   chk_out("post_rst_d0", 8'hFE, 8'h88);
    goto(5);   chk_out("post_rst_d1", 8'hFD, 8'h88);
    goto(32);  chk_fd("post_rst_fd", 1'b1);
    goto(33);  chk_out("post_rst_nopend", 8'hFE, 8'h88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
